// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // One write-back request as seen by the arbiter.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer.
// The pointer moves to the loser after every grant, even if the loser was idle.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio;
  logic w_prio_d;

  // Grant decode: a lone requester wins, otherwise prio picks the winner.
  always_comb begin
    o_gnt    = 2'b00;
    w_prio_d = r_prio;
    o_gnt[0] = i_req[0] & (~i_req[1] | ~r_prio);
    o_gnt[1] = i_req[1] & (~i_req[0] |  r_prio);
    if (o_gnt[0]) begin
      w_prio_d = 1'b1;
    end else if (o_gnt[1]) begin
      w_prio_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= w_prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus the
// per-register busy scoreboard used by decode to stall on pending writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = regfile_pkg::AW,
  parameter int unsigned DW   = regfile_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [31:0]   busy
);

  wb_req_t           w_wb0;
  wb_req_t           w_wb1;
  wb_req_t           w_sel;
  logic [NREQ-1:0]   w_req;
  logic [NREQ-1:0]   w_gnt;
  logic [NREGS-1:0]  w_busy_d;

  logic              r_we;
  logic [AW-1:0]     r_waddr;
  logic [DW-1:0]     r_wdata;
  logic [NREGS-1:0]  r_busy;

  // Bundle requests; valids are masked during reset so nobody sees ready.
  always_comb begin
    w_wb0 = '{valid: wb0_valid & rst_n, addr: wb0_addr, data: wb0_data};
    w_wb1 = '{valid: wb1_valid & rst_n, addr: wb1_addr, data: wb1_data};
    w_req = {w_wb1.valid, w_wb0.valid};
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign wb0_ready = w_gnt[0];
  assign wb1_ready = w_gnt[1];

  // Select the granted request; all-zero (valid=0) when nothing is granted.
  always_comb begin
    w_sel = '0;
    if (w_gnt[1]) begin
      w_sel = w_wb1;
    end else if (w_gnt[0]) begin
      w_sel = w_wb0;
    end
  end

  // Registered write port; $0 writes are handshaken but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_sel.valid) begin
      r_we    <= (w_sel.addr != REG_ZERO);
      r_waddr <= w_sel.addr;
      r_wdata <= w_sel.data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Scoreboard next state: clear on grant, then reserve (reserve wins).
  always_comb begin
    w_busy_d = r_busy;
    if (w_sel.valid) begin
      w_busy_d[w_sel.addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != REG_ZERO)) begin
      w_busy_d[rsv_addr] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb0_valid (wb0_valid),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    wb0_valid = 1'b1;
    wb0_addr  = 5'd3;
    wb0_data  = 32'h33;
    wb1_valid = 1'b1;
    wb1_addr  = 5'd4;
    wb1_data  = 32'h44;
    rsv_valid = 1'b0;
    rsv_addr  = 5'd0;

    // Reset held with both valid.
    step();
    step();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_rdy0", {31'd0, wb0_ready}, 32'd0);
    check("rst_rdy1", {31'd0, wb1_ready}, 32'd0);

    // Release: prio=0 so wb0 wins; then strict alternation 0,1,0,1,0,1.
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cont_rdy0_%0d", i), {31'd0, wb0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont_rdy1_%0d", i), {31'd0, wb1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check($sformatf("cont_we_%0d", i), {31'd0, rf_we}, 32'd1);
      check($sformatf("cont_waddr_%0d", i), {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd3 : 32'd4);
      check($sformatf("cont_wdata_%0d", i), rf_wdata, (i % 2 == 0) ? 32'h33 : 32'h44);
      #1;
    end
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;

    // Idle cycle: rf_we drops, address/data hold.
    step();
    check("idle_we", {31'd0, rf_we}, 32'd0);
    check("idle_waddr", {27'd0, rf_waddr}, 32'd4);

    // Single requester on wb1 (prio currently 0, wb1 still wins alone).
    wb1_valid = 1'b1;
    wb1_addr  = 5'd5;
    wb1_data  = 32'hDEADBEEF;
    #1;
    check("single_rdy1", {31'd0, wb1_ready}, 32'd1);
    check("single_rdy0", {31'd0, wb0_ready}, 32'd0);
    step();
    wb1_valid = 1'b0;
    check("single_we", {31'd0, rf_we}, 32'd1);
    check("single_waddr", {27'd0, rf_waddr}, 32'd5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    check("single_we_off", {31'd0, rf_we}, 32'd0);
    check("single_hold", rf_wdata, 32'hDEADBEEF);

    // Write to $0: handshaken, never enabled.
    wb0_valid = 1'b1;
    wb0_addr  = 5'd0;
    wb0_data  = 32'h1234;
    #1;
    check("z_rdy0", {31'd0, wb0_ready}, 32'd1);
    step();
    wb0_valid = 1'b0;
    check("z_we", {31'd0, rf_we}, 32'd0);
    check("z_busy0", {31'd0, busy[0]}, 32'd0);

    // Scoreboard: reserve 7.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    step();
    check("sb_set7", busy, 32'h0000_0080);
    // Reserve 7 and grant 7 in the same cycle: reserve wins.
    wb0_valid = 1'b1;
    wb0_addr  = 5'd7;
    wb0_data  = 32'h77;
    step();
    check("sb_same", busy, 32'h0000_0080);
    check("sb_same_we", {31'd0, rf_we}, 32'd1);
    // Grant 7 alone clears it.
    rsv_valid = 1'b0;
    step();
    wb0_valid = 1'b0;
    check("sb_clear", busy, 32'd0);
    // Reserve of $0 is ignored.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd0;
    step();
    rsv_valid = 1'b0;
    check("sb_rsv0", busy, 32'd0);

    // Async reset mid-op: grant wb0 addr 9 while reserving 12.
    wb0_valid = 1'b1;
    wb0_addr  = 5'd9;
    wb0_data  = 32'h99;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd12;
    step();
    rsv_valid = 1'b0;
    check("ar_we", {31'd0, rf_we}, 32'd1);
    check("ar_waddr", {27'd0, rf_waddr}, 32'd9);
    check("ar_busy", busy, 32'h0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we_drop", {31'd0, rf_we}, 32'd0);
    check("ar_busy_clr", busy, 32'd0);
    check("ar_waddr_clr", {27'd0, rf_waddr}, 32'd0);
    check("ar_rdy0", {31'd0, wb0_ready}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
